// File: rtl/mire_pkg.sv
// Shared types and constants for the colour-bar framebuffer writer.
package mire_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int BAR_SHIFT = 4;

  // Entry i is the colour of bar i: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] COLOUR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  localparam logic [23:0] MARKER_RGB = 24'hFFFFFF;

endpackage

// File: rtl/mire_writer_if.sv
// Wishbone write-master bus between the pattern writer and the SDRAM-side slave.
interface mire_writer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack
  );
endinterface

// File: rtl/mire_pattern.sv
// Combinational colour-bar generator: pixel (x, y) plus scroll offset s to 24-bit RGB.
module mire_pattern
  import mire_pkg::*;
#(
  parameter int VDISP = 480
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] s,
  output logic [23:0] rgb
);

  logic [15:0] pos;
  logic [2:0]  bar;

  always_comb begin
    pos = x + s;
    bar = pos[BAR_SHIFT +: 3];
    rgb = COLOUR_TABLE[bar];
    // First and last rows mark the frame edges.
    if (y == 16'd0 || y == 16'(VDISP - 1)) begin
      rgb = MARKER_RGB;
    end
  end

endmodule

// File: rtl/mire_writer.sv
// Wishbone master filling the framebuffer with colour bars in bounded bursts.
// Define MIRE_ANIMATE_EN to scroll the bars by one pixel per frame.
module mire_writer
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int GAP   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          frame_done,
  mire_writer_if.master bus
);

  state_t      state_reg;
  logic [15:0] x_reg, y_reg, bc_reg, gc_reg, fc_reg;
  logic [31:0] adr_reg, dat_reg;
  logic        cyc_reg, stb_reg, frame_done_reg;

  logic        last_x, last_y, frame_end;
  logic [15:0] x_next, y_next, fc_next, pat_s;
  logic [31:0] adr_next;
  logic [23:0] pat_rgb;

  // Position of the pixel that follows the one currently on the bus.
  always_comb begin
    last_x    = (x_reg == 16'(HDISP - 1));
    last_y    = (y_reg == 16'(VDISP - 1));
    frame_end = last_x && last_y;
    x_next    = last_x ? 16'd0 : x_reg + 16'd1;
    y_next    = last_x ? (last_y ? 16'd0 : y_reg + 16'd1) : y_reg;
    fc_next   = frame_end ? fc_reg + 16'd1 : fc_reg;
    adr_next  = frame_end ? 32'd0 : adr_reg + 32'd4;
  end

`ifdef MIRE_ANIMATE_EN
  assign pat_s = fc_next;
`else
  assign pat_s = 16'd0;
`endif

  mire_pattern #(
    .VDISP(VDISP)
  ) u_pattern (
    .x  (x_next),
    .y  (y_next),
    .s  (pat_s),
    .rgb(pat_rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      bc_reg         <= '0;
      gc_reg         <= '0;
      fc_reg         <= '0;
      adr_reg        <= '0;
      dat_reg        <= {8'h00, COLOUR_TABLE[0]};
      cyc_reg        <= 1'b0;
      stb_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg <= WRITE;
            cyc_reg   <= 1'b1;
            stb_reg   <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.ack) begin
            x_reg          <= x_next;
            y_reg          <= y_next;
            fc_reg         <= fc_next;
            adr_reg        <= adr_next;
            dat_reg        <= {8'h00, pat_rgb};
            frame_done_reg <= frame_end;
            // A full burst always takes the gap, even if enable has dropped.
            if (bc_reg == 16'(BURST - 1)) begin
              bc_reg    <= '0;
              gc_reg    <= '0;
              state_reg <= PAUSE;
              cyc_reg   <= 1'b0;
              stb_reg   <= 1'b0;
            end else begin
              bc_reg <= bc_reg + 16'd1;
              if (!enable) begin
                state_reg <= IDLE;
                cyc_reg   <= 1'b0;
                stb_reg   <= 1'b0;
              end
            end
          end
        end
        PAUSE: begin
          if (gc_reg == 16'(GAP - 1)) begin
            gc_reg <= '0;
            if (enable) begin
              state_reg <= WRITE;
              cyc_reg   <= 1'b1;
              stb_reg   <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            gc_reg <= gc_reg + 16'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cyc_reg   <= 1'b0;
          stb_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cyc    = cyc_reg;
  assign bus.stb    = stb_reg;
  assign bus.we     = 1'b1;
  assign bus.adr    = adr_reg;
  assign bus.dat_ms = dat_reg;
  assign bus.sel    = 4'hF;
  assign bus.cti    = 3'b000;
  assign bus.bte    = 2'b00;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_mire_writer.sv
// Self-checking bench for mire_writer: scoreboard of acked transfers plus a pattern table.
`timescale 1ns/1ps
module tb_mire_writer;

  localparam int HD   = 64;
  localparam int VD   = 4;
  localparam int BU   = 4;
  localparam int GP   = 2;
  localparam int NPIX = HD * VD;
`ifdef MIRE_ANIMATE_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic frame_done;

  mire_writer_if bus ();

  mire_writer #(
    .HDISP(HD),
    .VDISP(VD),
    .BURST(BU),
    .GAP  (GP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .frame_done(frame_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  typedef struct {
    int          px;
    int          py;
    logic [31:0] exp;
  } pat_vec_t;

  xfer_t       sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          waits = 0;
  int          wait_cnt = 0;
  bit          stray_ack_en = 1'b0;
  bit          gap_check_en = 1'b0;
  bit          cap_en = 1'b0;
  int          mx, my, mfc, mbc;
  bit          exp_fd;
  int          low_left;
  bit          expect_high;
  int          acks_since_fd;
  bit          prev_hold;
  logic [31:0] held_adr, held_dat, last_acked_adr;
  logic [31:0] cap0[NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pix(input int px, input int py, input int f);
    int s;
    int bar;
    logic [23:0] c;
    s   = ANIM ? f : 0;
    bar = ((((px + s) & 32'hFFFF) / 16) % 8);
    case (bar)
      0: c = 24'hFFFFFF;
      1: c = 24'hFFFF00;
      2: c = 24'h00FFFF;
      3: c = 24'h00FF00;
      4: c = 24'hFF00FF;
      5: c = 24'hFF0000;
      6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    if (py == 0 || py == VD - 1) c = 24'hFFFFFF;
    return {8'h00, c};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mfc = 0; mbc = 0;
    exp_fd = 1'b0; low_left = 0; expect_high = 1'b0;
    acks_since_fd = 0; prev_hold = 1'b0; wait_cnt = 0;
    sb_q.delete();
  endtask

  // One bus cycle: sample at the falling edge, check, then drive ack for the next rising edge.
  task automatic cycle();
    xfer_t e;
    xfer_t got;
    bit    do_ack;
    @(negedge clk);
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (frame_done) begin
      check("acks_per_frame", 32'(acks_since_fd), 32'(NPIX));
      acks_since_fd = 0;
    end
    exp_fd = 1'b0;
    if (gap_check_en) begin
      if (low_left > 0) begin
        check("gap_cyc_low", 32'(bus.cyc), 32'd0);
        low_left--;
        if (low_left == 0) expect_high = 1'b1;
      end else if (expect_high) begin
        check("gap_cyc_high", 32'(bus.cyc), 32'd1);
        expect_high = 1'b0;
      end
    end else begin
      low_left = 0;
      expect_high = 1'b0;
    end
    if (prev_hold) begin
      check("hold_stb", 32'(bus.stb), 32'd1);
      check("hold_adr", bus.adr, held_adr);
      check("hold_dat", bus.dat_ms, held_dat);
    end
    do_ack = 1'b0;
    if (bus.cyc && bus.stb) begin
      if (wait_cnt >= waits) begin
        do_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    if (do_ack) begin
      e.adr = 32'((my * HD + mx) * 4);
      e.dat = exp_pix(mx, my, mfc);
      sb_q.push_back(e);
      if (cap_en && mfc == 0) cap0[my * HD + mx] = bus.dat_ms;
`ifdef MIRE_ANIMATE_EN
      if (mfc == 3 && my == 1 && mx == 13) check("anim_f3_x13", bus.dat_ms, 32'h00FFFF00);
`endif
      mx++;
      if (mx == HD) begin
        mx = 0;
        my++;
        if (my == VD) begin
          my = 0;
          mfc = (mfc + 1) & 32'hFFFF;
          exp_fd = 1'b1;
        end
      end
      mbc++;
      if (mbc == BU) begin
        mbc = 0;
        low_left = GP;
      end
      acks_since_fd++;
      last_acked_adr = bus.adr;
      got = sb_q.pop_front();
      check("xfer_adr", bus.adr, got.adr);
      check("xfer_dat", bus.dat_ms, got.dat);
    end
    bus.ack   = do_ack | (stray_ack_en & ~bus.cyc);
    prev_hold = bus.stb && !do_ack;
    held_adr  = bus.adr;
    held_dat  = bus.dat_ms;
  endtask

  initial begin
    pat_vec_t tbl[12];
    bit found;
    bit saw_cyc;

    tbl[0]  = '{0,  0, 32'h00FFFFFF};
    tbl[1]  = '{15, 0, 32'h00FFFFFF};
    tbl[2]  = '{40, 0, 32'h00FFFFFF};
    tbl[3]  = '{16, 1, 32'h00FFFF00};
    tbl[4]  = '{48, 1, 32'h0000FF00};
    tbl[5]  = '{32, 1, 32'h0000FFFF};
    tbl[6]  = '{0,  1, 32'h00FFFFFF};
    tbl[7]  = '{63, 2, 32'h0000FF00};
    tbl[8]  = '{47, 2, 32'h0000FFFF};
    tbl[9]  = '{30, 2, 32'h00FFFF00};
    tbl[10] = '{15, 2, 32'h00FFFFFF};
    tbl[11] = '{20, 3, 32'h00FFFFFF};

    bus.ack = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cyc", 32'(bus.cyc), 32'd0);
    check("rst_stb", 32'(bus.stb), 32'd0);
    check("rst_adr", bus.adr, 32'd0);
    check("rst_dat", bus.dat_ms, 32'h00FFFFFF);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_we", 32'(bus.we), 32'd1);
    check("rst_sel", 32'(bus.sel), 32'hF);
    check("rst_cti", 32'(bus.cti), 32'd0);
    check("rst_bte", 32'(bus.bte), 32'd0);
    rst_n = 1'b1;

    // Stays idle with enable low
    repeat (2) begin
      cycle();
      check("idle_cyc", 32'(bus.cyc), 32'd0);
    end

    // Full-speed streaming with stray acks during gaps
    enable = 1'b1;
    gap_check_en = 1'b1;
    stray_ack_en = 1'b1;
    cap_en = 1'b1;
    cycle();
    check("first_stb", 32'(bus.stb), 32'd1);
    check("first_adr", bus.adr, 32'd0);
    for (int i = 0; i < 3000 && mfc < 2; i++) cycle();
    check("p2_frames", 32'(mfc), 32'd2);
    cap_en = 1'b0;

    for (int i = 0; i < 12; i++) begin
      $display("pattern x=%0d y=%0d got %h exp %h", tbl[i].px, tbl[i].py,
               cap0[tbl[i].py * HD + tbl[i].px], tbl[i].exp);
      check("pattern", cap0[tbl[i].py * HD + tbl[i].px], tbl[i].exp);
    end

    // Three wait states per transfer
    waits = 3;
    for (int i = 0; i < 6000 && mfc < 3; i++) cycle();
    check("p3_frames", 32'(mfc), 32'd3);

    waits = 0;
    for (int i = 0; i < 1000 && mfc < 4; i++) cycle();
    check("p4_frames", 32'(mfc), 32'd4);

    // Enable dropped during the transfer at adr 20
    waits = 1;
    gap_check_en = 1'b0;
    stray_ack_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle();
      if (bus.stb && bus.adr == 32'd20 && bus.ack == 1'b0) found = 1'b1;
    end
    check("find_adr20", 32'(found), 32'd1);
    enable = 1'b0;
    cycle();
    check("drop_ack_given", 32'(bus.ack), 32'd1);
    cycle();
    check("drop_acked_adr", last_acked_adr, 32'd20);
    check("drop_cyc_low", 32'(bus.cyc), 32'd0);
    saw_cyc = 1'b0;
    repeat (6) begin
      cycle();
      if (bus.cyc) saw_cyc = 1'b1;
    end
    check("drop_stays_idle", 32'(saw_cyc), 32'd0);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.stb) found = 1'b1;
    end
    check("resume_stb", 32'(found), 32'd1);
    check("resume_adr", bus.adr, 32'd24);

    // Asynchronous reset while stb is high at adr 36
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle();
      if (bus.stb && bus.adr == 32'd36) found = 1'b1;
    end
    check("find_adr36", 32'(found), 32'd1);
    rst_n = 1'b0;
    bus.ack = 1'b0;
    #1;
    check("arst_cyc", 32'(bus.cyc), 32'd0);
    check("arst_stb", 32'(bus.stb), 32'd0);
    check("arst_adr", bus.adr, 32'd0);
    check("arst_dat", bus.dat_ms, 32'h00FFFFFF);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waits = 0;
    gap_check_en = 1'b1;
    stray_ack_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      cycle();
      if (bus.stb) found = 1'b1;
    end
    check("restart_stb", 32'(found), 32'd1);
    check("restart_adr", bus.adr, 32'd0);
    repeat (60) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
